// File: rtl/rvx_dm_uart_bridge.sv
// Data-memory bridge: passes RAM-window traffic through to the data RAM and decodes a
// 16-byte MMIO window holding a TX byte FIFO, an 8N1 UART transmitter and a cycle counter.
module rvx_dm_uart_bridge #(
  parameter int unsigned BUS_W      = 32,
  parameter logic [31:0] MMIO_BASE  = 32'h1000_0000,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned BAUD_DIV   = 434
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [BUS_W-1:0] dmAddrIn,
  input  logic             dmWeIn,
  input  logic             dmReIn,
  input  logic [3:0]       dmDataWIn,
  input  logic [BUS_W-1:0] dmWDataIn,
  output logic [BUS_W-1:0] dmRDataOut,
  output logic [BUS_W-1:0] ramAddrOut,
  output logic             ramWeOut,
  output logic [3:0]       ramByteEnOut,
  output logic [BUS_W-1:0] ramWDataOut,
  input  logic [BUS_W-1:0] ramRDataIn,
  output logic             uartTxOut
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int BW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic [31:0]   cyc_q, cyc_d;
  state_e        state_q;
  logic          tx_q;
  logic [BW-1:0] baud_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;

  logic        mmio_sel, mmio_we, empty, full, busy, pop, push_req, push_ok, baud_last;
  logic [1:0]  off;
  logic [31:0] status;

  assign mmio_sel  = (dmAddrIn[31:4] == MMIO_BASE[31:4]);
  assign off       = dmAddrIn[3:2];
  assign mmio_we   = dmWeIn & mmio_sel;
  assign empty     = (cnt_q == '0);
  assign full      = (cnt_q == CW'(FIFO_DEPTH));
  assign busy      = (state_q != S_IDLE);
  assign pop       = (state_q == S_IDLE) & ~empty;
  assign push_req  = mmio_we & (off == 2'd0) & dmDataWIn[0];
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push_ok   = push_req & (~full | pop);
  assign baud_last = (baud_q == BW'(BAUD_DIV - 1));
  assign status    = {20'b0, ovf_q, busy, full, empty, 8'(cnt_q)};

  assign ramAddrOut   = dmAddrIn;
  assign ramWeOut     = dmWeIn & ~mmio_sel;
  assign ramByteEnOut = dmDataWIn;
  assign ramWDataOut  = dmWDataIn;
  assign uartTxOut    = tx_q;

  always_comb begin
    dmRDataOut = '0;
    if (dmReIn) begin
      if (!mmio_sel) dmRDataOut = ramRDataIn;
      else begin
        case (off)
          2'd1:    dmRDataOut = BUS_W'(status);
          2'd2:    dmRDataOut = BUS_W'(cyc_q);
          default: dmRDataOut = '0;
        endcase
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q + CW'(push_ok) - CW'(pop);
    ovf_d = ovf_q;
    if (push_req && !push_ok) ovf_d = 1'b1;
    if (mmio_we && off == 2'd1 && dmWDataIn[12] && dmDataWIn[1]) ovf_d = 1'b0;
    cyc_d = (mmio_we && off == 2'd2) ? dmWDataIn[31:0] : cyc_q + 32'd1;
  end

  // Storage has no reset; the pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= dmWDataIn[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      cyc_q  <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + PW'(1);
      if (pop)     rptr_q <= rptr_q + PW'(1);
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      cyc_q <= cyc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      tx_q    <= 1'b1;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (!empty) begin
          state_q <= S_START;
          tx_q    <= 1'b0;
          baud_q  <= '0;
          shift_q <= mem_q[rptr_q];
        end
        S_START: if (baud_last) begin
          baud_q  <= '0;
          bit_q   <= '0;
          state_q <= S_DATA;
          tx_q    <= shift_q[0];
        end else baud_q <= baud_q + BW'(1);
        S_DATA: if (baud_last) begin
          baud_q <= '0;
          if (bit_q == 3'd7) begin
            state_q <= S_STOP;
            tx_q    <= 1'b1;
          end else begin
            bit_q   <= bit_q + 3'd1;
            shift_q <= {1'b0, shift_q[7:1]};
            tx_q    <= shift_q[1];
          end
        end else baud_q <= baud_q + BW'(1);
        S_STOP: if (baud_last) begin
          baud_q  <= '0;
          state_q <= S_IDLE;
        end else baud_q <= baud_q + BW'(1);
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rvx_dm_uart_bridge.sv
// Scoreboarded bench: a queue/arithmetic reference model predicts every cycle's outputs.
`timescale 1ns/1ps
module tb_rvx_dm_uart_bridge;
  localparam int          B    = 4;
  localparam int          D    = 8;
  localparam logic [31:0] BASE = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rst, we, re, ram_we, tx;
  logic [31:0] addr, wdata, rdata, ram_addr, ram_wdata, ram_rdata;
  logic [3:0]  strb, be;

  always #5 clk = ~clk;

  rvx_dm_uart_bridge #(.BUS_W(32), .MMIO_BASE(BASE), .FIFO_DEPTH(D), .BAUD_DIV(B)) dut (
    .clk(clk), .rst(rst), .dmAddrIn(addr), .dmWeIn(we), .dmReIn(re), .dmDataWIn(strb),
    .dmWDataIn(wdata), .dmRDataOut(rdata), .ramAddrOut(ram_addr), .ramWeOut(ram_we),
    .ramByteEnOut(be), .ramWDataOut(ram_wdata), .ramRDataIn(ram_rdata), .uartTxOut(tx)
  );

  typedef struct {
    logic [31:0] rd;
    logic        ramwe;
    logic [3:0]  be;
    logic [31:0] raddr;
    logic [31:0] rwd;
    logic        tx;
  } exp_t;

  exp_t        expq[$];
  int          checks = 0, errors = 0;
  byte unsigned mq[$];
  logic        m_ovf = 1'b0;
  logic [31:0] m_cyc = '0;
  int          m_left = 0;
  logic [9:0]  m_frame = '0;
  bit          armed = 1'b0;

  // Reference model: evaluates the cycle whose inputs are stable, then steps to the next cycle.
  always @(negedge clk) begin
    exp_t        e;
    logic        mmio, pop, preq, acc;
    logic [1:0]  off;
    logic [31:0] st;
    byte unsigned b;
    mmio = (addr[31:4] == BASE[31:4]);
    off  = addr[3:2];
    if (armed) begin
      st = {20'b0, m_ovf, (m_left > 0), (mq.size() == D), (mq.size() == 0), 8'(mq.size())};
      if (!re)           e.rd = '0;
      else if (!mmio)    e.rd = ram_rdata;
      else if (off == 1) e.rd = st;
      else if (off == 2) e.rd = m_cyc;
      else               e.rd = '0;
      e.ramwe = we & ~mmio;
      e.be    = strb;
      e.raddr = addr;
      e.rwd   = wdata;
      e.tx    = (m_left > 0) ? m_frame[(10*B - m_left)/B] : 1'b1;
      expq.push_back(e);
    end
    if (rst) begin
      mq.delete();
      m_ovf = 1'b0; m_cyc = '0; m_left = 0; armed = 1'b1;
    end else if (armed) begin
      pop  = (m_left == 0) && (mq.size() > 0);
      preq = we && mmio && off == 0 && strb[0];
      acc  = preq && (mq.size() < D || pop);
      if (m_left > 0) m_left--;
      if (pop) begin
        b = mq.pop_front();
        m_frame = {1'b1, b, 1'b0};
        m_left  = 10*B;
      end
      if (acc) mq.push_back(wdata[7:0]);
      if (preq && !acc) m_ovf = 1'b1;
      if (we && mmio && off == 1 && wdata[12] && strb[1]) m_ovf = 1'b0;
      m_cyc = (we && mmio && off == 2) ? wdata : m_cyc + 32'd1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: drains the scoreboard after the model has pushed this cycle's prediction.
  always @(negedge clk) begin
    exp_t e;
    #2;
    while (expq.size() > 0) begin
      e = expq.pop_front();
      chk("rdata", rdata, e.rd);
      chk("ramWe", {31'b0, ram_we}, {31'b0, e.ramwe});
      chk("ramBe", {28'b0, be}, {28'b0, e.be});
      chk("ramAddr", ram_addr, e.raddr);
      chk("ramWData", ram_wdata, e.rwd);
      chk("uartTx", {31'b0, tx}, {31'b0, e.tx});
    end
  end

  task automatic drive(input logic w, input logic r, input logic [31:0] a,
                       input logic [3:0] s, input logic [31:0] d);
    we = w; re = r; addr = a; strb = s; wdata = d; ram_rdata = $urandom;
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rnd_addr();
    logic [31:0] a;
    if ($urandom_range(0, 3) == 0) a = {$urandom_range(0, 255), 2'b00} & 32'h0FFF_FFFC;
    else a = BASE + {28'b0, 2'($urandom_range(0, 3)), 2'b00};
    return a;
  endfunction

  // Read-only traffic: writes strobes/data with we=0 to show they are ignored.
  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b1, rnd_addr(), 4'($urandom), $urandom);
  endtask

  task automatic wait_model(input int mode);
    int guard = 0;
    while (guard < 2000) begin
      if (mode == 0 && m_left == 0 && mq.size() > 0) return;
      if (mode == 1 && m_left > B + 1 && m_left < 9*B - 1) return;
      idle(1);
      guard++;
    end
    checks++; errors++;
    $display("FAIL wait_model: mode %0d timed out, got left=%0d expected a matching state", mode, m_left);
  endtask

  initial begin
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    drive(1'b0, 1'b1, BASE + 32'h4, 4'h0, 32'h0);
    drive(1'b0, 1'b1, BASE + 32'h8, 4'h0, 32'h0);
    // Single frame 0xA5
    drive(1'b1, 1'b0, BASE, 4'b0001, 32'h0000_00A5);
    idle(45);
    // Overflow: fill while a frame is on the wire
    drive(1'b1, 1'b0, BASE, 4'b0001, 32'h0000_0011);
    idle(6);
    for (int i = 0; i < 9; i++) drive(1'b1, 1'b0, BASE, 4'b0001, 32'h20 + i);
    drive(1'b0, 1'b1, BASE + 32'h4, 4'h0, 32'h0);
    drive(1'b1, 1'b0, BASE + 32'h4, 4'b0010, 32'h0000_1000);
    drive(1'b0, 1'b1, BASE + 32'h4, 4'h0, 32'h0);
    // Full FIFO: push in the exact cycle the FSM pops
    wait_model(0);
    drive(1'b1, 1'b0, BASE, 4'b0001, 32'h0000_0077);
    drive(1'b0, 1'b1, BASE + 32'h4, 4'h0, 32'h0);
    // RAM routing vs ignored MMIO slot
    drive(1'b1, 1'b0, 32'h0000_0040, 4'b0011, 32'hDEAD_BEEF);
    drive(1'b1, 1'b0, BASE + 32'hC, 4'b0011, 32'hDEAD_BEEF);
    drive(1'b0, 1'b1, BASE + 32'h4, 4'h0, 32'h0);
    // Cycle counter wrap
    drive(1'b1, 1'b0, BASE + 32'h8, 4'b0001, 32'hFFFF_FFFE);
    repeat (3) drive(1'b0, 1'b1, BASE + 32'h8, 4'h0, 32'h0);
    // Reset in the middle of the data bits
    wait_model(1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(4);
    drive(1'b0, 1'b1, BASE + 32'h4, 4'h0, 32'h0);
    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      drive(($urandom_range(0, 9) < 3), $urandom_range(0, 1) == 1, rnd_addr(),
            4'($urandom), ($urandom_range(0, 1) == 1) ? $urandom : ($urandom & 32'h0000_10FF));
    end
    rst = 1'b0;
    idle(3);
    @(negedge clk); #4;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
